y86_regfile_mp: RTL and testbench

- Parametrised multi-port register file for the Y86-64 decode/writeback stages; generalises the 4-bit single-write decode register block.
- Two read ports (srcA/srcB), two write ports (dstE/dstM), RNONE handling, M-over-E write priority and a sticky error flag.
- Adds a per-register busy scoreboard so the pipelined core can detect RAW hazards at decode.

---
 rtl/y86_regfile_mp.sv | 238 +++++++++++++++++++++++
 tb/tb_y86_regfile_mp.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : y86_regfile_mp
//  Purpose  : Multi-port Y86-64 register file for the decode/writeback
//             stages. Two registered read ports, two write ports (E and M,
//             M wins on a shared destination), a per-register busy
//             scoreboard for RAW-hazard detection, and a sticky error flag.
//
//  Ports    : clk      - clock, all state changes on the rising edge
//             rst_n    - synchronous active-low reset
//             rd_en    - capture read data into val_a / val_b on this edge
//             src_a/b  - read indices; val_a/b - registered read data
//             wr_e_en, dst_e, val_e - E write port
//             wr_m_en, dst_m, val_m - M write port
//             rsv_en, rsv_reg       - mark a register busy
//             busy_a/b - combinational busy status of src_a / src_b
//             err_clr  - clear sticky error; err - sticky error flag
//
//  Build option:
//             RF_BYPASS_EN - when defined, a read on the same edge as a
//             write to the same register returns the write data (M over E).
//             When undefined, the read returns the pre-write content.
//
//  Revision : 1.0 - initial release
// ============================================================================
module y86_regfile_mp #(
    parameter int unsigned        DATA_W   = 64,
    parameter int unsigned        NUM_REGS = 15,
    parameter int unsigned        ADDR_W   = 4,
    parameter logic [ADDR_W-1:0]  RNONE    = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   src_a,
    input  logic [ADDR_W-1:0]   src_b,
    output logic [DATA_W-1:0]   val_a,
    output logic [DATA_W-1:0]   val_b,
    input  logic                wr_e_en,
    input  logic [ADDR_W-1:0]   dst_e,
    input  logic [DATA_W-1:0]   val_e,
    input  logic                wr_m_en,
    input  logic [ADDR_W-1:0]   dst_m,
    input  logic [DATA_W-1:0]   val_m,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_reg,
    output logic                busy_a,
    output logic                busy_b,
    input  logic                err_clr,
    output logic                err
);

    // Register count expressed at index width so every index comparison
    // happens at ADDR_W bits.
    localparam logic [ADDR_W-1:0] C_NUM_REGS = ADDR_W'(NUM_REGS);

    // ------------------------------------------------------------------
    // Index classification
    // ------------------------------------------------------------------
    // Index names a real architectural register.
    function automatic logic f_is_reg(input logic [ADDR_W-1:0] idx);
        return (idx != RNONE) && (idx < C_NUM_REGS);
    endfunction

    // Index is neither a register nor RNONE: an illegal encoding.
    function automatic logic f_is_bad(input logic [ADDR_W-1:0] idx);
        return (idx != RNONE) && (idx >= C_NUM_REGS);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_rf [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [DATA_W-1:0]   r_val_a;
    logic [DATA_W-1:0]   r_val_b;
    logic                r_err;

    // ------------------------------------------------------------------
    // Qualified requests
    // ------------------------------------------------------------------
    logic w_src_a_ok;
    logic w_src_b_ok;
    logic w_e_ok;
    logic w_m_ok;
    logic w_rsv_ok;
    logic w_collision;
    logic w_range_err;
    logic w_err_set;

    assign w_src_a_ok = f_is_reg(src_a);
    assign w_src_b_ok = f_is_reg(src_b);
    assign w_e_ok     = wr_e_en && f_is_reg(dst_e);
    assign w_m_ok     = wr_m_en && f_is_reg(dst_m);
    assign w_rsv_ok   = rsv_en  && f_is_reg(rsv_reg);

    // Both writers aiming at the same real register in one edge.
    assign w_collision = w_e_ok && w_m_ok && (dst_e == dst_m);

    // Out-of-range indices only count when the port that uses them is
    // active; idle ports may carry stale garbage.
    assign w_range_err = (rd_en   && (f_is_bad(src_a) || f_is_bad(src_b)))
                       || (wr_e_en && f_is_bad(dst_e))
                       || (wr_m_en && f_is_bad(dst_m))
                       || (rsv_en  && f_is_bad(rsv_reg));

    assign w_err_set = w_collision || w_range_err;

    // ------------------------------------------------------------------
    // Per-register write / reserve decode
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] w_hit_e;
    logic [NUM_REGS-1:0] w_hit_m;
    logic [NUM_REGS-1:0] w_hit_rsv;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign w_hit_e[gi]   = w_e_ok   && (dst_e   == ADDR_W'(gi));
            assign w_hit_m[gi]   = w_m_ok   && (dst_m   == ADDR_W'(gi));
            assign w_hit_rsv[gi] = w_rsv_ok && (rsv_reg == ADDR_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register array and scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst_n) begin
                r_rf[i]   <= '0;
                r_busy[i] <= 1'b0;
            end else begin
                // M is the later pipeline stage, so its value wins.
                if (w_hit_m[i]) begin
                    r_rf[i] <= val_m;
                end else if (w_hit_e[i]) begin
                    r_rf[i] <= val_e;
                end

                // A new reservation belongs to a younger instruction than
                // the one completing now, so it overrides the clear.
                if (w_hit_rsv[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_hit_e[i] || w_hit_m[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic              w_busy_a;
    logic              w_busy_b;

    // Array lookups; RNONE and out-of-range indices fall through to zero.
    always_comb begin
        w_rf_a   = '0;
        w_rf_b   = '0;
        w_busy_a = 1'b0;
        w_busy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_src_a_ok && (src_a == ADDR_W'(i))) begin
                w_rf_a   = r_rf[i];
                w_busy_a = r_busy[i];
            end
            if (w_src_b_ok && (src_b == ADDR_W'(i))) begin
                w_rf_b   = r_rf[i];
                w_busy_b = r_busy[i];
            end
        end
    end

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

`ifdef RF_BYPASS_EN
    // Forward same-edge write data. A matching dst is already known to be
    // a real register, so the source is implicitly valid too.
    always_comb begin
        w_rd_a = w_rf_a;
        w_rd_b = w_rf_b;
        if (w_m_ok && (dst_m == src_a)) begin
            w_rd_a = val_m;
        end else if (w_e_ok && (dst_e == src_a)) begin
            w_rd_a = val_e;
        end
        if (w_m_ok && (dst_m == src_b)) begin
            w_rd_b = val_m;
        end else if (w_e_ok && (dst_e == src_b)) begin
            w_rd_b = val_e;
        end
    end
`else
    // Reads see the pre-write content; new data appears on the next read.
    always_comb begin
        w_rd_a = w_rf_a;
        w_rd_b = w_rf_b;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_val_a <= '0;
            r_val_b <= '0;
        end else if (rd_en) begin
            r_val_a <= w_rd_a;
            r_val_b <= w_rd_b;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error: a new error in the clearing edge keeps the flag set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign val_a  = r_val_a;
    assign val_b  = r_val_b;
    assign busy_a = w_busy_a;
    assign busy_b = w_busy_b;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_y86_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y86_regfile_mp
//  Purpose  : Self-checking bench for y86_regfile_mp. Directed scenarios
//             followed by randomized traffic, all compared every cycle
//             against an array-based reference model of the register file.
//             Honors RF_BYPASS_EN in the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_y86_regfile_mp;

    localparam int          DW = 64;
    localparam int          NR = 15;
    localparam logic [3:0]  RN = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [3:0]    src_a, src_b;
    logic [DW-1:0] val_a, val_b;
    logic          wr_e_en;
    logic [3:0]    dst_e;
    logic [DW-1:0] val_e;
    logic          wr_m_en;
    logic [3:0]    dst_m;
    logic [DW-1:0] val_m;
    logic          rsv_en;
    logic [3:0]    rsv_reg;
    logic          busy_a, busy_b;
    logic          err_clr;
    logic          err;

    y86_regfile_mp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .src_a   (src_a),
        .src_b   (src_b),
        .val_a   (val_a),
        .val_b   (val_b),
        .wr_e_en (wr_e_en),
        .dst_e   (dst_e),
        .val_e   (val_e),
        .wr_m_en (wr_m_en),
        .dst_m   (dst_m),
        .val_m   (val_m),
        .rsv_en  (rsv_en),
        .rsv_reg (rsv_reg),
        .busy_a  (busy_a),
        .busy_b  (busy_b),
        .err_clr (err_clr),
        .err     (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_rf   [NR];
    bit            m_busy [NR];
    logic [DW-1:0] m_va, m_vb;
    bit            m_err;

    function automatic bit is_reg(input logic [3:0] idx);
        return (idx != RN) && (int'(idx) < NR);
    endfunction

    function automatic bit is_bad(input logic [3:0] idx);
        return (idx != RN) && (int'(idx) >= NR);
    endfunction

    function automatic bit m_busy_of(input logic [3:0] idx);
        if (!is_reg(idx)) return 1'b0;
        return m_busy[idx];
    endfunction

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        logic [DW-1:0] nrf [NR];
        bit coll, rng;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                m_rf[i]   = '0;
                m_busy[i] = 1'b0;
            end
            m_va  = '0;
            m_vb  = '0;
            m_err = 1'b0;
            return;
        end
        nrf = m_rf;
        if (wr_e_en && is_reg(dst_e)) nrf[dst_e] = val_e;
        if (wr_m_en && is_reg(dst_m)) nrf[dst_m] = val_m;   // M applied last
        if (rd_en) begin
`ifdef RF_BYPASS_EN
            m_va = is_reg(src_a) ? nrf[src_a] : '0;
            m_vb = is_reg(src_b) ? nrf[src_b] : '0;
`else
            m_va = is_reg(src_a) ? m_rf[src_a] : '0;
            m_vb = is_reg(src_b) ? m_rf[src_b] : '0;
`endif
        end
        if (wr_e_en && is_reg(dst_e)) m_busy[dst_e] = 1'b0;
        if (wr_m_en && is_reg(dst_m)) m_busy[dst_m] = 1'b0;
        if (rsv_en && is_reg(rsv_reg)) m_busy[rsv_reg] = 1'b1;
        coll = wr_e_en && wr_m_en && is_reg(dst_e) && (dst_e == dst_m);
        rng  = (rd_en && (is_bad(src_a) || is_bad(src_b))) ||
               (wr_e_en && is_bad(dst_e)) || (wr_m_en && is_bad(dst_m)) ||
               (rsv_en && is_bad(rsv_reg));
        if (coll || rng) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_rf = nrf;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge, clock the DUT, compare everything.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("val_a",  val_a,  m_va);
        chk("val_b",  val_b,  m_vb);
        chk("err",    {63'd0, err},    {63'd0, m_err});
        chk("busy_a", {63'd0, busy_a}, {63'd0, m_busy_of(src_a)});
        chk("busy_b", {63'd0, busy_b}, {63'd0, m_busy_of(src_b)});
    endtask

    task automatic idle();
        rd_en   = 1'b0; src_a = 4'd0; src_b = 4'd0;
        wr_e_en = 1'b0; dst_e = 4'd0; val_e = '0;
        wr_m_en = 1'b0; dst_m = 4'd0; val_m = '0;
        rsv_en  = 1'b0; rsv_reg = 4'd0;
        err_clr = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_rf[i]   = 'x;
            m_busy[i] = 1'b0;
        end
        m_va = 'x; m_vb = 'x; m_err = 1'b0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset clears state, even right after a write
        idle(); wr_e_en = 1'b1; dst_e = 4'd3; val_e = 64'hDEAD; rsv_en = 1'b1; rsv_reg = 4'd3;
        tick();
        idle(); rst_n = 1'b0; wr_e_en = 1'b1; dst_e = 4'd3; val_e = 64'hBEEF;
        tick();
        rst_n = 1'b1; idle(); rd_en = 1'b1; src_a = 4'd3; src_b = RN;
        tick();
        chk("rst_val_a", val_a, 64'h0);
        chk("rst_val_b", val_b, 64'h0);
        chk("rst_err",   {63'd0, err},    64'h0);
        chk("rst_busy_a", {63'd0, busy_a}, 64'h0);

        // Dual write then readback, then hold with rd_en low
        idle(); wr_e_en = 1'b1; dst_e = 4'd3; val_e = 64'h0B;
        wr_m_en = 1'b1; dst_m = 4'd13; val_m = 64'h06;
        tick();
        idle(); rd_en = 1'b1; src_a = 4'd3; src_b = 4'd13;
        tick();
        chk("wr_rd_a", val_a, 64'h0B);
        chk("wr_rd_b", val_b, 64'h06);
        idle(); src_a = 4'd1; src_b = 4'd2;
        tick();
        chk("hold_a", val_a, 64'h0B);
        chk("hold_b", val_b, 64'h06);

        // E/M collision: M wins and err is sticky until cleared
        idle(); wr_e_en = 1'b1; wr_m_en = 1'b1; dst_e = 4'd4; dst_m = 4'd4;
        val_e = 64'h11; val_m = 64'h22;
        tick();
        chk("coll_err", {63'd0, err}, 64'h1);
        idle();
        tick();
        chk("coll_sticky", {63'd0, err}, 64'h1);
        idle(); err_clr = 1'b1;
        tick();
        chk("coll_clr", {63'd0, err}, 64'h0);
        idle(); rd_en = 1'b1; src_a = 4'd4;
        tick();
        chk("coll_m_wins", val_a, 64'h22);
        // Collision and clear on the same edge: set wins
        idle(); wr_e_en = 1'b1; wr_m_en = 1'b1; dst_e = 4'd6; dst_m = 4'd6; err_clr = 1'b1;
        tick();
        chk("coll_vs_clr", {63'd0, err}, 64'h1);
        idle(); err_clr = 1'b1;
        tick();

        // Same-edge read/write
        idle(); wr_e_en = 1'b1; dst_e = 4'd5; val_e = 64'h01;
        tick();
        idle(); wr_m_en = 1'b1; dst_m = 4'd5; val_m = 64'h77; rd_en = 1'b1; src_a = 4'd5;
        tick();
`ifdef RF_BYPASS_EN
        chk("same_edge", val_a, 64'h77);
`else
        chk("same_edge", val_a, 64'h01);
`endif
        idle(); rd_en = 1'b1; src_a = 4'd5;
        tick();
        chk("after_edge", val_a, 64'h77);

        // Scoreboard
        idle(); rsv_en = 1'b1; rsv_reg = 4'd2; src_a = 4'd2;
        tick();
        chk("sb_set", {63'd0, busy_a}, 64'h1);
        idle(); src_a = 4'd2; wr_e_en = 1'b1; dst_e = 4'd2; val_e = 64'h9;
        rsv_en = 1'b1; rsv_reg = 4'd2;
        tick();
        chk("sb_set_wins", {63'd0, busy_a}, 64'h1);
        idle(); src_a = 4'd2; wr_m_en = 1'b1; dst_m = 4'd2; val_m = 64'hA;
        tick();
        chk("sb_clear", {63'd0, busy_a}, 64'h0);

        // RNONE handling
        idle(); rsv_en = 1'b1; rsv_reg = 4'd7;
        tick();
        idle(); wr_e_en = 1'b1; dst_e = RN; val_e = 64'h55; rsv_en = 1'b1; rsv_reg = RN;
        src_a = 4'd7; src_b = RN;
        tick();
        chk("rnone_err",   {63'd0, err},    64'h0);
        chk("rnone_busy7", {63'd0, busy_a}, 64'h1);
        chk("rnone_busyb", {63'd0, busy_b}, 64'h0);
        for (int r = 0; r < NR; r += 2) begin
            idle(); rd_en = 1'b1; src_a = 4'(r); src_b = 4'(r + 1);
            tick();
        end
        idle(); rd_en = 1'b1; src_a = RN; src_b = 4'd13;
        tick();
        chk("rnone_read", val_a, 64'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rst_n   = ($urandom_range(0, 59) != 0);
            rd_en   = $urandom_range(0, 1) == 1;
            src_a   = 4'($urandom_range(0, 15));
            src_b   = 4'($urandom_range(0, 15));
            wr_e_en = $urandom_range(0, 2) != 0;
            dst_e   = 4'($urandom_range(0, 15));
            val_e   = {$urandom(), $urandom()};
            wr_m_en = $urandom_range(0, 2) != 0;
            dst_m   = ($urandom_range(0, 5) == 0) ? dst_e : 4'($urandom_range(0, 15));
            val_m   = {$urandom(), $urandom()};
            rsv_en  = $urandom_range(0, 1) == 1;
            rsv_reg = ($urandom_range(0, 3) == 0) ? dst_e : 4'($urandom_range(0, 15));
            err_clr = $urandom_range(0, 3) == 0;
            tick();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
